// File: rtl/finalsoc_midi_rx_pkg.sv
// Shared definitions for the MIDI receiver: FSM state encoding, Avalon register
// addresses and the bit positions used in the STATUS and CONTROL registers.
package finalsoc_midi_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  // Register map
  localparam logic [1:0] AddrData    = 2'd0;
  localparam logic [1:0] AddrStatus  = 2'd1;
  localparam logic [1:0] AddrControl = 2'd2;

  // STATUS bit indices
  localparam int unsigned StatNotEmpty = 0;
  localparam int unsigned StatFull     = 1;
  localparam int unsigned StatOvr      = 2;
  localparam int unsigned StatFerr     = 3;
  localparam int unsigned StatCountLsb = 8;

  // CONTROL bit indices
  localparam int unsigned CtrlIe    = 0;
  localparam int unsigned CtrlFlush = 1;

  // DATA register valid flag
  localparam int unsigned DataValid = 8;

endpackage

// File: rtl/midi_rx_fifo.sv
// Byte FIFO for received MIDI bytes.
// Ports: clk_i/rst_i (async active-high), push_i/data_i write side, pop_i read
// side (data_o is the head byte), flush_i empties the FIFO and wins over push,
// full_o/empty_o/count_o status, drop_o pulses when a push is lost to a full FIFO.
module midi_rx_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [7:0]                 data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [7:0]                 data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       drop_o
);

  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned CountW = AddrW + 1;

  logic [7:0]       mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic do_push, do_pop;

  assign full_o  = (count_q == CountW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CountW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CountW'(1);
    end
  end

  // Storage is not reset; reads of an empty FIFO are masked by the register file.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/finalsoc_midi_rx.sv
// MIDI (8N1) serial receiver with an Avalon-MM slave register interface.
// Ports: clk/reset (async active-high); address/chipselect/read_n/write_n/
// writedata/readdata Avalon slave (readdata combinational, zero wait states);
// midi_rx asynchronous serial input (idle high); irq = IE & FIFO not empty.
module finalsoc_midi_rx
  import finalsoc_midi_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 31250,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        midi_rx,
  output logic        irq
);

  localparam int unsigned Div    = CLK_HZ / BAUD;
  localparam int unsigned Half   = Div / 2;
  localparam int unsigned CntW   = $clog2(Div);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  // Synchronizer
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], midi_rx};
  end
  assign rx_s = sync_q[1];

  // Receive FSM
  rx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      byte_q;
  logic            push_q;
  logic            ferr_set_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= StStart;
        end
        // Half-bit resample rejects glitches and aligns later samples to bit centres.
        StStart: begin
          if (cnt_q == CntW'(Half - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntW'(Div - 1)) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= StStop;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == CntW'(Div - 1)) begin
            cnt_q <= '0;
            if (rx_s) begin
              byte_q  <= shift_q;
              push_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              ferr_set_q <= 1'b1;
              state_q    <= StWaitHigh;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitHigh: begin
          cnt_q <= '0;
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Bus decode
  logic wr_en, pop, flush;
  assign wr_en = chipselect & ~write_n;
  assign pop   = chipselect & ~read_n & (address == AddrData);
  assign flush = wr_en & (address == AddrControl) & writedata[CtrlFlush];

  logic [7:0]        fifo_head;
  logic              fifo_full, fifo_empty, fifo_drop;
  logic [CountW-1:0] fifo_count;

  midi_rx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push_q),
    .data_i  (byte_q),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  // Flags and control
  logic ovr_q, ferr_q, ie_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      ie_q   <= 1'b0;
    end else begin
      if (wr_en && address == AddrStatus) begin
        if (writedata[StatOvr])  ovr_q  <= 1'b0;
        if (writedata[StatFerr]) ferr_q <= 1'b0;
      end
      // Later assignments win: a coincident set overrides the W1C clear.
      if (fifo_drop)  ovr_q  <= 1'b1;
      if (ferr_set_q) ferr_q <= 1'b1;
      if (wr_en && address == AddrControl) ie_q <= writedata[CtrlIe];
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:4];

  always_comb begin
    readdata = '0;
    case (address)
      AddrData: begin
        if (!fifo_empty) begin
          readdata[7:0]       = fifo_head;
          readdata[DataValid] = 1'b1;
        end
      end
      AddrStatus: begin
        readdata[StatNotEmpty]            = ~fifo_empty;
        readdata[StatFull]                = fifo_full;
        readdata[StatOvr]                 = ovr_q;
        readdata[StatFerr]                = ferr_q;
        readdata[StatCountLsb +: CountW]  = fifo_count;
      end
      AddrControl: readdata[CtrlIe] = ie_q;
      default: ;
    endcase
  end

  assign irq = ie_q & ~fifo_empty;

endmodule

// File: tb/tb_finalsoc_midi_rx.sv
// Self-checking bench for finalsoc_midi_rx: directed frames plus a randomized
// phase, a queue-based reference model and a scoreboard checked on every read.
module tb_finalsoc_midi_rx;

  localparam int unsigned ClkHz = 3200000;
  localparam int unsigned Baud  = 100000;
  localparam int unsigned Depth = 16;
  localparam int unsigned Div   = ClkHz / Baud;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        midi_rx;
  logic        irq;

  always #5 clk = ~clk;

  finalsoc_midi_rx #(
    .CLK_HZ     (ClkHz),
    .BAUD       (Baud),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .midi_rx    (midi_rx),
    .irq        (irq)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: received bytes as a plain queue plus flags.
  logic [7:0] model_q[$];
  bit m_ovr, m_ferr, m_ie;

  // Scoreboard of expected read responses.
  logic [31:0] exp_val_q[$];
  logic [1:0]  exp_addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string addr_name(input logic [1:0] a);
    case (a)
      2'd0:    return "read_data";
      2'd1:    return "read_status";
      2'd2:    return "read_control";
      default: return "read_addr3";
    endcase
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0]    = (model_q.size() != 0);
    s[1]    = (model_q.size() == Depth);
    s[2]    = m_ovr;
    s[3]    = m_ferr;
    s[15:8] = 8'(model_q.size());
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    logic [31:0] v;
    case (a)
      2'd0:    v = (model_q.size() != 0) ? {23'b0, 1'b1, model_q.pop_front()} : 32'h0;
      2'd1:    v = model_status();
      2'd2:    v = {31'b0, m_ie};
      default: v = 32'h0;
    endcase
    exp_val_q.push_back(v);
    exp_addr_q.push_back(a);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    tick(1);
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    if (a == 2'd1) begin
      if (d[2]) m_ovr  = 1'b0;
      if (d[3]) m_ferr = 1'b0;
    end else if (a == 2'd2) begin
      m_ie = d[0];
      if (d[1]) model_q.delete();
    end
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check_irq(input string name);
    check(name, {31'b0, irq}, {31'b0, m_ie && (model_q.size() != 0)});
  endtask

  // One 8N1 frame; a bad stop bit is followed by a bit time of idle-high line.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    midi_rx = 1'b0;
    tick(Div);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      tick(Div);
    end
    midi_rx = stop;
    tick(Div);
    midi_rx = 1'b1;
    if (!stop) tick(Div);
    if (stop) begin
      if (model_q.size() < Depth) model_q.push_back(b);
      else                        m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_ie = 1'b0;
    tick(2);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check("reset_readdata", readdata, 32'h0);
    end
    check("reset_irq", {31'b0, irq}, 32'h0);
    midi_rx = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
  endtask

  // Monitor: every DUT read response is compared to the scoreboard head.
  always @(negedge clk) begin
    if (!reset && chipselect && !read_n) begin
      if (exp_val_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got 0x%08h expected no read", readdata);
      end else begin
        check(addr_name(exp_addr_q.pop_front()), readdata, exp_val_q.pop_front());
      end
    end
  end

  initial begin
    #(400000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; midi_rx = 1'b1; address = 2'd0; chipselect = 1'b0;
    read_n = 1'b1; write_n = 1'b1; writedata = '0;
    tick(1);
    apply_reset();
    for (int a = 0; a < 4; a++) bus_read(2'(a));

    // Single byte
    send_frame(8'h90, 1'b1);
    tick(4);
    bus_read(2'd1);
    bus_read(2'd0);
    bus_read(2'd0);

    // Back-to-back bytes with interrupts enabled
    bus_write(2'd2, 32'h1);
    send_frame(8'h90, 1'b1);
    check_irq("irq_after_first");
    send_frame(8'h3C, 1'b1);
    send_frame(8'h7F, 1'b1);
    tick(2);
    bus_read(2'd0);
    bus_read(2'd0);
    check_irq("irq_before_last_read");
    bus_read(2'd0);
    check_irq("irq_after_last_read");

    // Overflow
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
    tick(2);
    bus_read(2'd1);
    for (int i = 0; i < 16; i++) bus_read(2'd0);
    bus_write(2'd1, 32'h4);
    bus_read(2'd1);

    // Framing error then recovery
    send_frame(8'h55, 1'b0);
    bus_read(2'd1);
    send_frame(8'hAA, 1'b1);
    tick(2);
    bus_read(2'd0);
    bus_write(2'd1, 32'h8);
    bus_read(2'd1);

    // Short low glitch
    midi_rx = 1'b0;
    tick(Div / 4);
    midi_rx = 1'b1;
    tick(2 * Div);
    bus_read(2'd1);

    // Reset in the middle of bit 4 of 0xF0
    midi_rx = 1'b0;
    tick(Div);
    for (int i = 0; i < 4; i++) begin
      midi_rx = 1'b0;  // bits 0..3 of 0xF0
      tick(Div);
    end
    midi_rx = 1'b1;
    tick(Div / 2);
    apply_reset();
    bus_read(2'd1);
    bus_read(2'd2);
    send_frame(8'hF8, 1'b1);
    tick(2);
    bus_read(2'd0);

    // Randomized traffic
    bus_write(2'd2, 32'h1);
    for (int n = 0; n < 40; n++) begin
      logic [31:0] d;
      tick($urandom_range(0, Div));
      send_frame(8'($urandom), ($urandom_range(0, 7) != 0));
      tick(2);
      check_irq("irq_random");
      for (int r = $urandom_range(0, 3); r > 0; r--) bus_read(2'($urandom_range(0, 3)));
      case ($urandom_range(0, 5))
        0: begin d = $urandom; bus_write(2'd1, d); end
        1: begin
          d = $urandom;
          d[1] = ($urandom_range(0, 7) == 0);
          bus_write(2'd2, d);
        end
        2: begin d = $urandom; bus_write(2'd3, d); end
        default: ;
      endcase
    end
    bus_read(2'd1);
    while (model_q.size() != 0) bus_read(2'd0);
    bus_read(2'd0);
    bus_read(2'd1);

    tick(3);
    check("scoreboard_drain", 32'(exp_val_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
